// File: rtl/pipe_ctl_defs.sv
// Stage-control encodings and FSM state type
// shared by the hazard unit and pipeline regs.
package pipe_ctl_defs;

  localparam logic [1:0] CTL_ADV   = 2'd0;
  localparam logic [1:0] CTL_HOLD  = 2'd1;
  localparam logic [1:0] CTL_FLUSH = 2'd2;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_MDU = 1'b1
  } state_t;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] ifid;
    logic [1:0] idexe;
  } stage_ctl_t;

  function automatic stage_ctl_t mk_ctl(
    input logic [1:0] pc,
    input logic [1:0] ifid,
    input logic [1:0] idexe
  );
    stage_ctl_t c;
    c.pc    = pc;
    c.ifid  = ifid;
    c.idexe = idexe;
    return c;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EXE whose dest
// is read by the ID instruction (r0 exempt).
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs_hit;
  logic rt_hit;

  // Register-match terms combined with the load flag
  always_comb begin
    rs_hit   = id_use_rs && (id_rs == ex_rd);
    rt_hit   = id_use_rt && (id_rt == ex_rd);
    load_use = ex_mem_read && (ex_rd != 5'd0)
             && (rs_hit || rt_hit);
  end

endmodule

// File: rtl/hazard_ctl.sv
// Hazard/control unit: load-use bubble, branch
// flush, mult/div occupancy and stall counter.
module hazard_ctl
  import pipe_ctl_defs::*;
#(
  parameter int MDU_CYCLES = 32,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        id_mdu,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_br_taken,
  output logic [1:0]  pc_ctl,
  output logic [1:0]  ifid_ctl,
  output logic [1:0]  idexe_ctl,
  output logic        mdu_busy,
  output logic [31:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(MDU_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_use;
  stage_ctl_t       ctl;

  hazard_detect u_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // State and occupancy counter registers
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: branch and load-use outrank a
  // mult/div issue since they squash or hold it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (!ex_br_taken && !load_use && id_mdu) begin
          state_d = ST_MDU;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_MDU: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Stage controls; reset overrides everything
  always_comb begin
    ctl      = mk_ctl(CTL_ADV, CTL_ADV, CTL_ADV);
    mdu_busy = 1'b0;
    if (!Reset) begin
      ctl = mk_ctl(CTL_HOLD, CTL_FLUSH, CTL_FLUSH);
    end else if (state_q == ST_MDU) begin
      ctl      = mk_ctl(CTL_HOLD, CTL_HOLD, CTL_HOLD);
      mdu_busy = 1'b1;
    end else if (ex_br_taken) begin
      ctl = mk_ctl(CTL_ADV, CTL_FLUSH, CTL_FLUSH);
    end else if (load_use) begin
      ctl = mk_ctl(CTL_HOLD, CTL_HOLD, CTL_FLUSH);
    end
    pc_ctl    = ctl.pc;
    ifid_ctl  = ctl.ifid;
    idexe_ctl = ctl.idexe;
  end

  // Debug count of PC-hold cycles, wraps at 2^32
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
    end else if (pc_ctl == CTL_HOLD) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctl.sv
// Testbench for hazard_ctl: vector table plus
// MDU, reset and wrap sequences.
module tb_hazard_ctl;

  typedef struct packed {
    logic       rstn;
    logic       br;
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       mdu;
    logic [1:0] pc;
    logic [1:0] ifid;
    logic [1:0] idexe;
    logic       busy;
  } vec_t;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] ifid;
    logic [1:0] idexe;
    logic       busy;
  } exp_t;

  logic        clk;
  logic        Reset;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_use_rs, id_use_rt, id_mdu;
  logic        ex_mem_read, ex_br_taken;
  logic [1:0]  pc4, ifid4, idexe4;
  logic [1:0]  pc1, ifid1, idexe1;
  logic        busy4, busy1;
  logic [31:0] cnt4, cnt1;

  int          errors;
  int          checks;
  logic [31:0] sb_stall;
  exp_t        sb_q[$];
  vec_t        tbl[10];

  hazard_ctl #(.MDU_CYCLES(4), .CNT_W(8)) dut4 (
    .clk(clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu(id_mdu), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_br_taken(ex_br_taken),
    .pc_ctl(pc4), .ifid_ctl(ifid4),
    .idexe_ctl(idexe4), .mdu_busy(busy4),
    .stall_cnt(cnt4)
  );

  hazard_ctl #(.MDU_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_mdu(id_mdu), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read),
    .ex_br_taken(ex_br_taken),
    .pc_ctl(pc1), .ifid_ctl(ifid1),
    .idexe_ctl(idexe1), .mdu_busy(busy1),
    .stall_cnt(cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(
    input logic rstn, input logic br,
    input logic mr, input logic [4:0] rd,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt,
    input logic mdu, input logic [1:0] pc,
    input logic [1:0] ifid, input logic [1:0] idexe,
    input logic busy
  );
    vec_t v;
    v = '{rstn, br, mr, rd, rs, rt, urs, urt, mdu,
          pc, ifid, idexe, busy};
    return v;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    chk({tag, ":stall_cnt"}, cnt4, sb_stall);
    Reset       = v.rstn;
    ex_br_taken = v.br;
    ex_mem_read = v.mr;
    ex_rd       = v.rd;
    id_rs       = v.rs;
    id_rt       = v.rt;
    id_use_rs   = v.urs;
    id_use_rt   = v.urt;
    id_mdu      = v.mdu;
    if (!v.rstn) sb_stall = 32'd0;
    sb_q.push_back('{v.pc, v.ifid, v.idexe, v.busy});
    @(negedge clk);
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk({tag, ":ctl"},
          {25'd0, pc4, ifid4, idexe4, busy4},
          {25'd0, e.pc, e.ifid, e.idexe, e.busy});
      if (v.rstn && e.pc == 2'd1)
        sb_stall = sb_stall + 32'd1;
    end
  endtask

  function automatic vec_t idle();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t hold();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1);
  endfunction

  function automatic vec_t mdu_in(input logic [1:0] c,
                                  input logic b,
                                  input logic br);
    return mk(1, br, 0, 0, 0, 0, 0, 0, 1, c, c, c, b);
  endfunction

  initial begin
    errors      = 0;
    checks      = 0;
    sb_stall    = 32'd0;
    Reset       = 1'b0;
    ex_br_taken = 1'b1;
    id_mdu      = 1'b1;
    ex_mem_read = 1'b0;
    ex_rd       = 5'd0;
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_use_rs   = 1'b0;
    id_use_rt   = 1'b0;

    // load-use, r0, rs/rt paths, branch priority
    tbl[0] = mk(1,0,1,5,0,5,0,1,0, 1,1,2,0);
    tbl[1] = mk(1,0,1,0,0,0,0,1,0, 0,0,0,0);
    tbl[2] = mk(1,0,1,9,9,3,1,0,0, 1,1,2,0);
    tbl[3] = mk(1,0,1,9,9,3,0,1,0, 0,0,0,0);
    tbl[4] = mk(1,0,0,5,0,5,0,1,0, 0,0,0,0);
    tbl[5] = mk(1,1,1,5,0,5,0,1,0, 0,2,2,0);
    tbl[6] = mk(1,1,0,0,0,0,0,0,0, 0,2,2,0);
    tbl[7] = mk(1,0,1,7,6,8,1,1,0, 0,0,0,0);
    tbl[8] = mk(1,0,1,31,4,31,1,1,0, 1,1,2,0);
    tbl[9] = mk(1,1,1,5,0,5,0,1,1, 0,2,2,0);

    for (int i = 0; i < 3; i++)
      step(mk(0,1,0,0,0,0,0,0,1, 1,2,2,0), "reset");
    step(idle(), "reset_release");

    for (int i = 0; i < 10; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
      step(idle(), $sformatf("vec%0d_idle", i));
    end

    // MDU with 4-cycle occupancy
    step(mdu_in(0, 0, 0), "mdu4_issue");
    for (int i = 0; i < 4; i++)
      step(hold(), $sformatf("mdu4_hold%0d", i));
    step(idle(), "mdu4_done");

    // 1-cycle instance alongside the 4-cycle one
    step(mdu_in(0, 0, 0), "mdu1_issue");
    chk("mdu1_issue_ctl", {29'd0, pc1, busy1}, 32'd0);
    step(hold(), "mdu1_h0");
    chk("mdu1_hold", {25'd0, pc1, ifid1, idexe1, busy1},
        32'b0101011);
    step(hold(), "mdu1_h1");
    chk("mdu1_after", {25'd0, pc1, ifid1, idexe1, busy1},
        32'd0);
    step(hold(), "mdu1_h2");
    step(hold(), "mdu1_h3");
    step(idle(), "mdu1_done");

    // reset on the 2nd hold cycle
    step(mdu_in(0, 0, 0), "rmid_issue");
    step(hold(), "rmid_h0");
    step(mk(0,0,0,0,0,0,0,0,0, 1,2,2,0), "rmid_rst");
    step(idle(), "rmid_rel");
    step(idle(), "rmid_idle");

    // preload near wrap, then back-to-back MDU
    force dut4.stall_cnt = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut4.stall_cnt;
    sb_stall = 32'hFFFF_FFFF;
    for (int r = 0; r < 2; r++) begin
      step(mdu_in(0, 0, 0), $sformatf("b2b%0d_adv", r));
      for (int i = 0; i < 4; i++)
        step(mdu_in(1, 1, (i == 1)),
             $sformatf("b2b%0d_h%0d", r, i));
    end
    step(idle(), "b2b_end");
    step(idle(), "b2b_idle");
    chk("wrap_value", sb_stall, 32'd7);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hazard_ctl.md
Name: hazard_ctl

Overview:
- Pipeline hazard and control unit for the 5-stage MIPS core.
- Produces the 2-bit stage-control codes consumed by the PC register, the IF/ID register and the ID/EXE register.
- Handles three cases:
  - load-use stalls, by inserting a bubble into EXE;
  - taken-branch flushes, with the branch resolved in EXE;
  - multi-cycle multiply/divide occupancy, via a registered busy state machine with a down-counter.
- Also keeps a free-running stall-cycle counter for debug.

Parameters:
- MDU_CYCLES, 32, cycles EXE is occupied by a mult/div instruction (legal range 1..255)
- CNT_W, 8, width of the MDU down-counter (must hold MDU_CYCLES-1)

Ports:
- clk  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- id_rs  in  5  rs field of instruction in ID
- id_rt  in  5  rt field of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_mdu  in  1  ID instruction is mult/div
- ex_rd  in  5  destination register of instruction in EXE
- ex_mem_read  in  1  EXE instruction is a load
- ex_br_taken  in  1  branch/jump in EXE resolved taken
- pc_ctl  out  2  PC register control
- ifid_ctl  out  2  IF/ID register control
- idexe_ctl  out  2  ID/EXE register control
- mdu_busy  out  1  state == MDU
- stall_cnt  out  32  cycles with pc_ctl == HOLD since reset

Behaviour:
- Control encoding (shared):
  - ADV = 2'd0: load;
  - HOLD = 2'd1: keep value;
  - FLUSH = 2'd2: clear to 0;
  - 2'd3 is never driven.
- Control outputs are combinational from registered state plus current inputs. State, counter and stall_cnt are registered on the rising edge of clk.
- Reset (Reset=0, asynchronous):
  - state=RUN, cnt=0, stall_cnt=0;
  - outputs forced to pc_ctl=HOLD, ifid_ctl=FLUSH, idexe_ctl=FLUSH, mdu_busy=0 while Reset=0, independent of other inputs.
- load_use = ex_mem_read & (ex_rd != 0) & ((id_use_rs & id_rs == ex_rd) | (id_use_rt & id_rt == ex_rd)).
- State RUN, evaluated in priority order:
  1. ex_br_taken=1: pc=ADV (PC takes target), ifid=FLUSH, idexe=FLUSH. Load-use and id_mdu are ignored because the ID instruction is squashed. Stay in RUN.
  2. load_use=1: pc=HOLD, ifid=HOLD, idexe=FLUSH (bubble). Stay in RUN. The stall lasts exactly 1 cycle, because the load leaves EXE.
  3. id_mdu=1: pc=ADV, ifid=ADV, idexe=ADV (mult/div enters EXE). Next state MDU, cnt <= MDU_CYCLES-1.
  4. Otherwise: all ADV.
- State MDU:
  - pc=HOLD, ifid=HOLD, idexe=HOLD; mdu_busy=1.
  - ex_br_taken and load_use are ignored; EXE holds the mult/div, which cannot be a branch or load.
  - cnt != 0: cnt <= cnt-1, stay in MDU.
  - cnt == 0: next state RUN. The pipeline therefore holds exactly MDU_CYCLES cycles, and all ADV resumes on the following cycle.
  - MDU_CYCLES=1 gives a single HOLD cycle.
- Back-to-back mult/div: the second one sits in ID during MDU. On return to RUN it issues, and the unit re-enters MDU immediately after one ADV cycle.
- stall_cnt:
  - increments by 1 on every clock edge where Reset=1 and pc_ctl==HOLD;
  - wraps modulo 2^32;
  - flushes alone do not count.
- Reset asserted mid-MDU: state returns to RUN at once and cnt clears. No residual HOLD after Reset deasserts.
- Register 0 never causes a hazard.

Decomposition:
- Shared package/include `pipe_ctl_defs`:
  - CTL_ADV, CTL_HOLD, CTL_FLUSH localparams (2-bit);
  - state encoding ST_RUN=1'b0, ST_MDU=1'b1.
- The ID/EXE, IF/ID and PC registers use the same constants.
- One natural sub-module: `hazard_detect`. It is purely combinational, computes load_use from the ID/EXE register fields, and can be reused for forwarding checks.
- The FSM, counter and stall_cnt stay in hazard_ctl.

Test Plan:
1. Reset: hold Reset=0 for 3 cycles with ex_br_taken=1 and id_mdu=1 applied.
   - Outputs must be pc=1, ifid=2, idexe=2 and stall_cnt=0.
   - After release with idle inputs, all ctl=0.
2. Load-use: ex_mem_read=1, ex_rd=5, id_use_rt=1, id_rt=5 for 1 cycle.
   - That cycle: pc=1, ifid=1, idexe=2; stall_cnt becomes 1.
   - Repeat with ex_rd=0: all 0, no count.
3. Branch priority: ex_br_taken=1 together with the load-use condition of test 2.
   - Outputs must be pc=0, ifid=2, idexe=2; stall_cnt unchanged.
4. MDU with MDU_CYCLES=4: id_mdu=1 for 1 cycle.
   - That cycle is all 0.
   - The next 4 cycles are all 1 with mdu_busy=1.
   - Then all 0; stall_cnt increments by 4.
   - Repeat with MDU_CYCLES=1: exactly 1 HOLD cycle.
5. Reset mid-MDU: assert Reset=0 during the 2nd HOLD cycle.
   - mdu_busy=0 immediately.
   - After release, all ctl=0 with no leftover HOLD.
6. Back-to-back MDU, with id_mdu held at 1 (MDU_CYCLES=4):
   - the sequence repeats ADV, HOLD×4, ADV, HOLD×4;
   - ex_br_taken pulsed during HOLD is ignored;
   - stall_cnt wraps from 32'hFFFFFFFF to 0 when preloaded via force.
